// File: rtl/swipt_seq_pkg.sv
// Shared types and default operating point for the SWIPT program sequencer.
package swipt_seq_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_FREQ = 2'b01,
        PH_MEAS = 2'b10,
        PH_DATA = 2'b11
    } phase_t;

    localparam logic [19:0] FREQ_DEFAULT = 20'h9470;
    localparam logic [11:0] DUTY_DEFAULT = 12'hC8;
    localparam logic [11:0] DUTY_MIN     = 12'h32;
    localparam logic [11:0] DUTY_MAX     = 12'h1F4;

endpackage

// File: rtl/swipt_duty_step.sv
// Combinational saturating duty step: next = duty +/- duty/STEP_DIV, clamped to [duty_min, duty_max].
module swipt_duty_step #(
    parameter int DUTY_W   = 12,
    parameter int STEP_DIV = 10
) (
    input  logic [DUTY_W-1:0] duty,
    input  logic              up,
    input  logic [DUTY_W-1:0] duty_min,
    input  logic [DUTY_W-1:0] duty_max,
    output logic [DUTY_W-1:0] duty_next
);

    localparam logic [DUTY_W:0] DIV = (DUTY_W+1)'(STEP_DIV);

    // One extra bit so neither the sum nor the compare can wrap
    logic [DUTY_W:0] duty_x;
    logic [DUTY_W:0] step;
    logic [DUTY_W:0] sum;
    logic [DUTY_W:0] diff;

    always_comb begin
        duty_x = {1'b0, duty};
        step   = duty_x / DIV;
        sum    = duty_x + step;
        diff   = duty_x - step;
        if (up) begin
            duty_next = (sum < {1'b0, duty_max}) ? sum[DUTY_W-1:0] : duty_max;
        end else begin
            duty_next = (diff > {1'b0, duty_min}) ? diff[DUTY_W-1:0] : duty_min;
        end
    end

endmodule

// File: rtl/swipt_sequencer.sv
// SWIPT program sequencer: owns freq/duty and steps IDLE -> FREQ -> MEAS -> DATA.
// Optional periodic re-optimisation from DATA back to FREQ: define SWIPT_SEQ_REOPT_EN.
module swipt_sequencer #(
    parameter int                FREQ_W        = 20,
    parameter int                DUTY_W        = 12,
    parameter int                CNT_W         = 24,
    parameter logic [FREQ_W-1:0] FREQ_DEFAULT  = FREQ_W'(swipt_seq_pkg::FREQ_DEFAULT),
    parameter logic [DUTY_W-1:0] DUTY_DEFAULT  = DUTY_W'(swipt_seq_pkg::DUTY_DEFAULT),
    parameter logic [DUTY_W-1:0] DUTY_MIN      = DUTY_W'(swipt_seq_pkg::DUTY_MIN),
    parameter logic [DUTY_W-1:0] DUTY_MAX      = DUTY_W'(swipt_seq_pkg::DUTY_MAX),
    parameter int                STEP_DIV      = 10,
    parameter int                SETTLE_CYCLES = 5_000_000,
    parameter int                MEAS_CYCLES   = 2_000_000,
    parameter int                REOPT_PERIOD  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swipt_alive,
    input  logic              comms_ovr,
    input  logic [FREQ_W-1:0] comms_freq,
    input  logic [DUTY_W-1:0] comms_duty,
    input  logic              freq_done,
    input  logic [FREQ_W-1:0] freq_new,
    input  logic [FREQ_W-1:0] freq_best,
    input  logic              get_mean,
    input  logic              duty_rdy,
    input  logic              duty_up,
    output logic [1:0]        phase,
    output logic [FREQ_W-1:0] freq,
    output logic [DUTY_W-1:0] duty,
    output logic              measure,
    output logic              meas_done
);

    import swipt_seq_pkg::*;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES + MEAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LIM   = CNT_W'(MEAS_CYCLES);

    phase_t            state_q, state_n;
    logic [FREQ_W-1:0] freq_q, freq_n;
    logic [DUTY_W-1:0] duty_q, duty_n;
    logic [DUTY_W-1:0] duty_stepped;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              measure_q, measure_n;
    logic              meas_done_q, meas_done_n;

`ifdef SWIPT_SEQ_REOPT_EN
    localparam int              UPD_W     = $clog2(REOPT_PERIOD + 1);
    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(REOPT_PERIOD - 1);
    logic [UPD_W-1:0] upd_q, upd_n;
`endif

    swipt_duty_step #(
        .DUTY_W   (DUTY_W),
        .STEP_DIV (STEP_DIV)
    ) u_duty_step (
        .duty      (duty_q),
        .up        (duty_up),
        .duty_min  (DUTY_MIN),
        .duty_max  (DUTY_MAX),
        .duty_next (duty_stepped)
    );

    // Heartbeat loss is treated exactly like reset
    always_ff @(posedge clk) begin
        if (!nrst || !swipt_alive) begin
            state_q     <= PH_IDLE;
            freq_q      <= FREQ_DEFAULT;
            duty_q      <= DUTY_DEFAULT;
            cnt_q       <= CNT_RELOAD;
            measure_q   <= 1'b0;
            meas_done_q <= 1'b0;
`ifdef SWIPT_SEQ_REOPT_EN
            upd_q       <= '0;
`endif
        end else begin
            state_q     <= state_n;
            freq_q      <= freq_n;
            duty_q      <= duty_n;
            cnt_q       <= cnt_n;
            measure_q   <= measure_n;
            meas_done_q <= meas_done_n;
`ifdef SWIPT_SEQ_REOPT_EN
            upd_q       <= upd_n;
`endif
        end
    end

    always_comb begin
        state_n     = state_q;
        freq_n      = freq_q;
        duty_n      = duty_q;
        cnt_n       = cnt_q;
        measure_n   = 1'b0;
        meas_done_n = 1'b0;
`ifdef SWIPT_SEQ_REOPT_EN
        upd_n       = upd_q;
`endif
        if (comms_ovr) begin
            freq_n  = comms_freq;
            duty_n  = comms_duty;
            state_n = PH_IDLE;
            cnt_n   = CNT_RELOAD;
`ifdef SWIPT_SEQ_REOPT_EN
            upd_n   = '0;
`endif
        end else begin
            case (state_q)
                PH_IDLE: begin
                    state_n = PH_FREQ;
                    cnt_n   = CNT_RELOAD;
`ifdef SWIPT_SEQ_REOPT_EN
                    upd_n   = '0;
`endif
                end
                PH_FREQ: begin
                    if (freq_done) begin
                        freq_n    = freq_best;
                        state_n   = PH_MEAS;
                        cnt_n     = CNT_RELOAD;
                        measure_n = (CNT_RELOAD < MEAS_LIM);
                    end else begin
                        freq_n = freq_new;
                    end
                end
                PH_MEAS: begin
                    // measure tracks the count the window will hold next cycle
                    if (cnt_q == '0) begin
                        state_n     = PH_DATA;
                        meas_done_n = 1'b1;
                        cnt_n       = CNT_RELOAD;
                    end else begin
                        cnt_n     = cnt_q - 1'b1;
                        measure_n = (cnt_n < MEAS_LIM);
                    end
                end
                PH_DATA: begin
                    measure_n = get_mean;
                    if (duty_rdy) begin
                        duty_n = duty_stepped;
`ifdef SWIPT_SEQ_REOPT_EN
                        if (upd_q == UPD_LAST) begin
                            state_n   = PH_FREQ;
                            measure_n = 1'b0;
                            upd_n     = '0;
                        end else begin
                            upd_n = upd_q + 1'b1;
                        end
`endif
                    end
                end
                default: state_n = PH_IDLE;
            endcase
        end
    end

    assign phase     = state_q;
    assign freq      = freq_q;
    assign duty      = duty_q;
    assign measure   = measure_q;
    assign meas_done = meas_done_q;

endmodule
